// File: rtl/md_unit_pkg.sv
// md_unit_pkg: MDOp encodings and FSM states shared by md_unit, the controller and the hazard unit.
// The madd family is decodable only when MDU_MADD_EN is defined.
package md_unit_pkg;

    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MADD  = 4'd7;
    localparam logic [3:0] MD_MADDU = 4'd8;
    localparam logic [3:0] MD_MSUB  = 4'd9;
    localparam logic [3:0] MD_MSUBU = 4'd10;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} md_state_t;

    function automatic logic is_div_op(input logic [3:0] op);
        return op == MD_DIV || op == MD_DIVU;
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return op == MD_MULT || op == MD_DIV || op == MD_MADD || op == MD_MSUB;
    endfunction

    function automatic logic is_long_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
`else
        return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
`endif
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// md_unit_if: E-stage issue bundle into the multiply/divide unit and its HI/LO/busy view.
interface md_unit_if;
    logic        start;
    logic [3:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    modport master (output start, MDOp, A, B, input busy, HI, LO);
    modport slave  (input start, MDOp, A, B, output busy, HI, LO);
endinterface

// File: rtl/md_counter.sv
// md_counter: loadable down-counter; done is high while the count sits at 1 (last busy cycle).
module md_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    assign done = cnt == W'(1);
endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning HI/LO for mfhi/mflo.
// Define MDU_MADD_EN to add madd/maddu/msub/msubu with a 64-bit accumulate.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic      clk,
    input logic      reset,
    md_unit_if.slave md
);
    localparam int MAX_CYCLES = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    md_state_t   state, state_d;
    logic [3:0]  op_q;
    logic [31:0] a_q, b_q, hi_q, lo_q, hi_d, lo_d;
    logic        accept, done, sgn, sa, sb;
    logic [31:0] ua, ub, uq, ur, quo, rem;
    logic [63:0] prod, mul_res;

    assign accept = state == IDLE && md.start && is_long_op(md.MDOp);

    md_counter #(.W(CW)) u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (is_div_op(md.MDOp) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES)),
        .done     (done)
    );

    // One 64x64 multiplier serves both signednesses: sign-extend only for signed ops.
    assign sgn  = is_signed_op(op_q);
    assign sa   = sgn & a_q[31];
    assign sb   = sgn & b_q[31];
    assign prod = {{32{sa}}, a_q} * {{32{sb}}, b_q};
`ifdef MDU_MADD_EN
    assign mul_res = op_q inside {MD_MADD, MD_MADDU} ? {hi_q, lo_q} + prod :
                     op_q inside {MD_MSUB, MD_MSUBU} ? {hi_q, lo_q} - prod : prod;
`else
    assign mul_res = prod;
`endif

    // Divide on magnitudes, then fix signs: quotient truncates toward zero, remainder follows dividend.
    assign ua  = sa ? -a_q : a_q;
    assign ub  = sb ? -b_q : b_q;
    assign uq  = ub == '0 ? '0 : ua / ub;
    assign ur  = ub == '0 ? '0 : ua % ub;
    assign quo = (sa ^ sb) ? -uq : uq;
    assign rem = sa ? -ur : ur;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= IDLE;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            state <= state_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            if (accept) begin
                op_q <= md.MDOp;
                a_q  <= md.A;
                b_q  <= md.B;
            end
        end

    always_comb begin
        state_d = state;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (state == IDLE) begin
            hi_d    = md.start && md.MDOp == MD_MTHI ? md.A : hi_q;
            lo_d    = md.start && md.MDOp == MD_MTLO ? md.A : lo_q;
            state_d = accept ? RUN : IDLE;
        end else if (done) begin
            state_d = IDLE;
            if (!is_div_op(op_q)) {hi_d, lo_d} = mul_res;
            else if (b_q != '0) {hi_d, lo_d} = {rem, quo};
        end
    end

    assign md.busy = state == RUN;
    assign md.HI   = hi_q;
    assign md.LO   = lo_q;
endmodule
